// File: rtl/axi_lite_seq_pkg.sv
// rtl/axi_lite_seq_pkg.sv - shared types and constants for the AXI4-Lite command sequencer
//
// Purpose : command record, sequencer state encoding and response codes.
//           SEQ_DATA_WIDTH / SEQ_ADDRESS fix the cmd_t field widths and must
//           equal the DATA_WIDTH / ADDRESS parameters of the sequencer top.
package axi_lite_seq_pkg;

    localparam int SEQ_DATA_WIDTH = 32;
    localparam int SEQ_ADDRESS    = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic                      write;
        logic [SEQ_ADDRESS-1:0]    addr;
        logic [SEQ_DATA_WIDTH-1:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_B,
        WAIT_R,
        RESP
    } state_t;

endpackage

// File: rtl/axi_lite_cmd_sequencer_if.sv
// rtl/axi_lite_cmd_sequencer_if.sv - client, top-side and snoop signals of the command sequencer
//
// Purpose : bundles every non-clock port of axi_lite_cmd_sequencer.
// Signals : cmd_*      client command push (valid/ready)
//           read_s, write_s, address, W_data   start pulse + operands to the AXI top
//           M_B*, M_R* snooped B/R channel handshakes
//           rsp_*      response return (valid/ready), busy status
// Modports: slave  - the sequencer view
//           master - the client / environment view
interface axi_lite_cmd_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDRESS-1:0]    cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  read_s;
    logic                  write_s;
    logic [ADDRESS-1:0]    address;
    logic [DATA_WIDTH-1:0] W_data;

    logic                  M_BVALID;
    logic                  M_BREADY;
    logic [1:0]            M_BRESP;
    logic                  M_RVALID;
    logic                  M_RREADY;
    logic [DATA_WIDTH-1:0] M_RDATA;
    logic [1:0]            M_RRESP;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [1:0]            rsp_resp;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  M_BVALID, M_BREADY, M_BRESP, M_RVALID, M_RREADY, M_RDATA, M_RRESP,
        input  rsp_ready,
        output cmd_ready, read_s, write_s, address, W_data,
        output rsp_valid, rsp_write, rsp_data, rsp_resp, busy
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output M_BVALID, M_BREADY, M_BRESP, M_RVALID, M_RREADY, M_RDATA, M_RRESP,
        output rsp_ready,
        input  cmd_ready, read_s, write_s, address, W_data,
        input  rsp_valid, rsp_write, rsp_data, rsp_resp, busy
    );
endinterface

// File: rtl/axi_lite_cmd_fifo.sv
// rtl/axi_lite_cmd_fifo.sv - synchronous FIFO of cmd_t entries
//
// Purpose : command buffer between the client and the sequencer FSM.
// Ports   : clk, rst (sync active-high)
//           push, push_data          write one entry (ignored when full)
//           pop, pop_data            head entry (combinational), pop advances it (ignored when empty)
//           full, empty, count       occupancy, count is clog2(DEPTH)+1 bits
import axi_lite_seq_pkg::*;

module axi_lite_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    cmd_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full     = (r_count == (PW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    // Storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly PW bits so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/axi_lite_cmd_sequencer.sv
// rtl/axi_lite_cmd_sequencer.sv - queues client commands and issues them one at a time to the AXI4-Lite top
//
// Purpose : buffers commands, pulses read_s/write_s with address/W_data held,
//           snoops B/R handshakes for completion and returns one response per command.
// Ports   : ACLK, ARESET (sync active-high)
//           bus   axi_lite_cmd_sequencer_if.slave (client, top-side, snoop, response)
//           stat_wr_cnt, stat_rd_cnt, stat_err_cnt  only with AXI_LITE_SEQ_STATS_EN
// Macro   : AXI_LITE_SEQ_STATS_EN adds saturating accepted-response counters.
import axi_lite_seq_pkg::*;

module axi_lite_cmd_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    axi_lite_cmd_sequencer_if.slave         bus
`ifdef AXI_LITE_SEQ_STATS_EN
    ,
    output logic [15:0]                     stat_wr_cnt,
    output logic [15:0]                     stat_rd_cnt,
    output logic [15:0]                     stat_err_cnt
`endif
);
    state_t                    r_state;
    state_t                    w_next;
    cmd_t                      r_cmd;
    cmd_t                      w_push_cmd;
    cmd_t                      w_head;
    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_b_hs;
    logic                      w_r_hs;
    logic                      w_rsp_accept;
    logic                      r_rsp_write;
    logic [DATA_WIDTH-1:0]     r_rsp_data;
    logic [1:0]                r_rsp_resp;

    assign w_push     = bus.cmd_valid && !w_full;
    assign w_push_cmd = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign w_b_hs     = bus.M_BVALID && bus.M_BREADY;
    assign w_r_hs     = bus.M_RVALID && bus.M_RREADY;
    assign w_rsp_accept = (r_state == RESP) && bus.rsp_ready;

    axi_lite_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (w_push),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next = ISSUE;
                    w_pop  = 1'b1;
                end
            end
            ISSUE:  w_next = r_cmd.write ? WAIT_B : WAIT_R;
            WAIT_B: if (w_b_hs) w_next = RESP;
            WAIT_R: if (w_r_hs) w_next = RESP;
            RESP: begin
                // Back-to-back: the next head is popped on the accept cycle itself.
                if (bus.rsp_ready) begin
                    if (!w_empty) begin
                        w_next = ISSUE;
                        w_pop  = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_resp  <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_cmd <= w_head;
            if ((r_state == WAIT_B) && w_b_hs) begin
                r_rsp_write <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_resp  <= bus.M_BRESP;
            end
            if ((r_state == WAIT_R) && w_r_hs) begin
                r_rsp_write <= 1'b0;
                r_rsp_data  <= bus.M_RDATA;
                r_rsp_resp  <= bus.M_RRESP;
            end
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.write_s   = (r_state == ISSUE) &&  r_cmd.write;
    assign bus.read_s    = (r_state == ISSUE) && !r_cmd.write;
    assign bus.address   = r_cmd.addr;
    assign bus.W_data    = r_cmd.wdata;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_write = r_rsp_write;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_resp  = r_rsp_resp;
    assign bus.busy      = !w_empty || (r_state != IDLE);

`ifdef AXI_LITE_SEQ_STATS_EN
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_err;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_stat_wr  <= '0;
            r_stat_rd  <= '0;
            r_stat_err <= '0;
        end else if (w_rsp_accept) begin
            if (r_rsp_write  && (r_stat_wr  != 16'hFFFF)) r_stat_wr  <= r_stat_wr  + 16'd1;
            if (!r_rsp_write && (r_stat_rd  != 16'hFFFF)) r_stat_rd  <= r_stat_rd  + 16'd1;
            if ((r_rsp_resp != RESP_OKAY) && (r_stat_err != 16'hFFFF)) r_stat_err <= r_stat_err + 16'd1;
        end
    end

    assign stat_wr_cnt  = r_stat_wr;
    assign stat_rd_cnt  = r_stat_rd;
    assign stat_err_cnt = r_stat_err;
`else
    logic w_unused;
    assign w_unused = w_rsp_accept ^ (|w_count) ^ (|RESP_SLVERR);
`endif
endmodule

// File: doc/axi_lite_cmd_sequencer.md
Name: axi_lite_cmd_sequencer

Overview:
- Upstream command source for the AXI4-Lite master/slave top.
- Buffers read/write commands from a valid/ready client in a FIFO and issues them one at a time as read_s/write_s pulses with address/W_data held stable.
- Tracks completion by snooping the B and R channel handshakes, then returns one response per command on a valid/ready response port.

Parameters:
- DATA_WIDTH, 32, data width; must match the top.
- ADDRESS, 32, address width; must match the top.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- cmd_valid  in  1  client command valid
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDRESS  command address
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- read_s  out  1  one-cycle read start pulse to top
- write_s  out  1  one-cycle write start pulse to top
- address  out  ADDRESS  to top
- W_data  out  DATA_WIDTH  to top
- M_BVALID, M_BREADY  in  1 each  snooped B handshake
- M_BRESP  in  2  snooped write response
- M_RVALID, M_RREADY  in  1 each  snooped R handshake
- M_RDATA  in  DATA_WIDTH  snooped read data
- M_RRESP  in  2  snooped read response
- rsp_valid  out  1  response valid
- rsp_ready  in  1  client accepts response
- rsp_write  out  1  response belongs to a write
- rsp_data  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP captured
- busy  out  1  FIFO non-empty or state≠IDLE

Behaviour:
- Reset (ARESET=1 at a rising ACLK edge):
  - Empty the FIFO and enter IDLE.
  - All outputs go to 0 except cmd_ready, which goes to 1.
  - Reset mid-transaction abandons the command and produces no response.
- Command push: cmd_valid&&cmd_ready writes one entry. cmd_ready = !full, registered-free (combinational from count).
- States:
  - IDLE → ISSUE when the FIFO is non-empty. Pop the head into the cmd register and drive address/W_data from it.
  - ISSUE: assert write_s or read_s for exactly one cycle. → WAIT_B (write) or WAIT_R (read).
  - WAIT_B: on M_BVALID&&M_BREADY, capture M_BRESP with rsp_write=1 and rsp_data=0. → RESP.
  - WAIT_R: on M_RVALID&&M_RREADY, capture M_RDATA/M_RRESP with rsp_write=0. → RESP.
  - RESP: hold rsp_valid=1 and response fields stable until rsp_ready. Leave RESP on the rsp_valid&&rsp_ready cycle: → ISSUE if the FIFO is non-empty (pop in the same cycle), else IDLE.
- address/W_data hold the current command from ISSUE until leaving RESP. Between commands they hold their last value.
- Handshakes in the wrong state are ignored; B/R handshakes seen in IDLE/ISSUE/RESP do not change state.
- Latency: a command pushed at edge N into an empty, idle block pulses the start signal at edge N+2; rsp_valid asserts on the edge after the completing handshake.
- Simultaneous push and pop: both occur; count is unchanged.
- Full FIFO: cmd_ready=0; pushes are blocked. Push when full is impossible by protocol.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Only one command is outstanding at a time; no reordering.

Optional Feature:
- Macro AXI_LITE_SEQ_STATS_EN.
- When defined, add outputs stat_wr_cnt[15:0], stat_rd_cnt[15:0] and stat_err_cnt[15:0].
  - stat_wr_cnt / stat_rd_cnt increment on each write/read response accepted (rsp_valid&&rsp_ready).
  - stat_err_cnt increments when the accepted response has rsp_resp≠2'b00.
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package axi_lite_seq_pkg:
  - cmd_t struct {write, addr, wdata} parameterised via localparams.
  - state enum {IDLE, ISSUE, WAIT_B, WAIT_R, RESP}.
  - Constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- Sub-module axi_lite_cmd_fifo: synchronous FIFO of cmd_t (push/pop/full/empty/count), same clock/reset.

Test Plan:
- Single write: push write addr=32'h10, data=32'hDEADBEEF → one write_s pulse two cycles later; address=32'h10 and W_data=32'hDEADBEEF held; after B handshake with BRESP=00 → rsp_valid, rsp_write=1, rsp_resp=00, rsp_data=0.
- Single read: push read addr=32'h10 after the write → one read_s pulse; R handshake RDATA=32'hDEADBEEF, RRESP=00 → rsp_data=32'hDEADBEEF, rsp_write=0.
- Fill FIFO: push 5 commands back-to-back with FIFO_DEPTH=4 and no completions → cmd_ready=0 after the FIFO is full. All 5 commands are eventually issued in order, with strictly one start pulse per response.
- Response backpressure: hold rsp_ready=0 for 10 cycles → rsp fields stable, no new start pulse; release → next command issues on the following cycle.
- Error response: slave returns BRESP=2'b10 → rsp_resp=2'b10. With AXI_LITE_SEQ_STATS_EN, stat_err_cnt=1 and stat_wr_cnt=1.
- Reset mid-operation: assert ARESET in WAIT_R with 2 queued commands → next cycle idle, busy=0, cmd_ready=1, no rsp_valid, no further start pulses.
